// File: rtl/btn_cond_pkg.sv
// Shared types and constants for the three-channel push-button conditioner.
// Build option: BTN_COND_AUTOREPEAT_EN adds periodic repeat presses while a button is held.
package btn_cond_pkg;

  localparam int NUM_BTN = 3;

  // Channel indices into btn_raw / pulse / level; a lower index means higher arbitration priority.
  localparam int BTN_C = 0;
  localparam int BTN_F = 1;
  localparam int BTN_P = 2;

`ifdef BTN_COND_AUTOREPEAT_EN
  localparam bit AUTOREPEAT_EN = 1'b1;
`else
  localparam bit AUTOREPEAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_e;

  // The counter must reach DEBOUNCE_CYCLES-1. With auto-repeat it must also reach REPEAT_CYCLES-1.
  function automatic int cnt_width(input int debounce_cycles, input int repeat_cycles,
                                   input bit autorepeat);
    int span;
    span = (autorepeat && (repeat_cycles > debounce_cycles)) ? repeat_cycles : debounce_cycles;
    return $clog2(span);
  endfunction

endpackage

// File: rtl/btn_cond_if.sv
// Button-side bundle of the conditioner: raw inputs in, press strobes, levels and busy out.
// The DUT takes the slave modport and the driver takes the master modport.
interface btn_cond_if;
  import btn_cond_pkg::*;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] pulse;
  logic [NUM_BTN-1:0] level;
  logic               busy;

  modport master (
    output btn_raw,
    input  pulse,
    input  level,
    input  busy
  );

  modport slave (
    input  btn_raw,
    output pulse,
    output level,
    output busy
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: a 2-flop synchroniser and a debounce FSM with a shared counter.
// It raises a one-cycle pend_set when a press is accepted, and on each auto-repeat when BTN_COND_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_CYCLES   = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic pend_set
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES, AUTOREPEAT_EN);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_COND_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             meta_q,  meta_d;
  logic             sync_q,  sync_d;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    meta_d   = btn_raw;
    sync_d   = meta_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d  = HELD;
          cnt_d    = '0;
          pend_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HELD: begin
        if (!sync_q) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
`ifdef BTN_COND_AUTOREPEAT_EN
        // A held button re-arms its pending bit once per repeat period.
        else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          pend_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      REL_WAIT: begin
        if (sync_q) begin
          // A bounce during release returns to HELD without a new press.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = (state_q == HELD) || (state_q == REL_WAIT);

  // NOTE: sequential state updates use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/btn_cond.sv
// Three-channel button conditioner: per-channel debounce plus a fixed-priority (C > F > P) serialiser.
// It emits at most one registered press pulse per cycle. Auto-repeat is enabled by BTN_COND_AUTOREPEAT_EN.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_CYCLES   = 500
) (
  input  logic       clk,
  input  logic       reset,
  btn_cond_if.slave  bus
);

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] pend_set;
  logic [NUM_BTN-1:0] grant;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] pulse_q,   pulse_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn_raw  (bus.btn_raw[i]),
      .level    (level_w[i]),
      .pend_set (pend_set[i])
    );
  end

  always_comb begin
    grant = '0;
    if (pending_q[BTN_C])      grant[BTN_C] = 1'b1;
    else if (pending_q[BTN_F]) grant[BTN_F] = 1'b1;
    else if (pending_q[BTN_P]) grant[BTN_P] = 1'b1;

    // The set is applied after the clear, so a new press is kept even if its own bit is being granted on this edge.
    pending_d = (pending_q & ~grant) | pend_set;
    pulse_d   = grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      pulse_q   <= '0;
    end else begin
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
    end
  end

  assign bus.pulse = pulse_q;
  assign bus.level = level_w;
  assign bus.busy  = |pending_q;

endmodule

// File: tb/tb_btn_cond.sv
// Self-checking bench for btn_cond (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10) with a run-length reference model.
// Follows the BTN_COND_AUTOREPEAT_EN build option in its expectations.
module tb_btn_cond;
  import btn_cond_pkg::*;

  localparam int DEB = 4;
  localparam int REP = 10;
`ifdef BTN_COND_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  btn_cond_if bus ();

  btn_cond #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model. A channel flips its level after DEB+1 consecutive synchronised samples that disagree with it.
  logic [2:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_pend = '0, m_pulse = '0;
  int         m_run[3];
  int         m_rep[3];

  task automatic model_edge(input logic [2:0] raw, input logic rst);
    logic [2:0] grant, fresh;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pend = '0; m_pulse = '0;
      for (int c = 0; c < 3; c++) begin m_run[c] = 0; m_rep[c] = 0; end
    end else begin
      grant = m_pend & (~m_pend + 3'd1);
      fresh = '0;
      for (int c = 0; c < 3; c++) begin
        if (m_s2[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB + 1) begin
            m_level[c] = m_s2[c];
            m_run[c]   = 0;
            m_rep[c]   = 0;
            if (m_level[c]) fresh[c] = 1'b1;
          end
        end else if (m_run[c] != 0) begin
          m_run[c] = 0;
          m_rep[c] = 0;
        end else if (AUTO && m_level[c]) begin
          if (m_rep[c] == REP - 1) begin
            fresh[c] = 1'b1;
            m_rep[c] = 0;
          end else begin
            m_rep[c]++;
          end
        end
      end
      m_pend  = (m_pend & ~grant) | fresh;
      m_pulse = grant;
      m_s2    = m_s1;
      m_s1    = raw;
    end
  endtask

  task automatic tick(input logic [2:0] raw, input logic rst);
    @(negedge clk);
    bus.btn_raw = raw;
    reset       = rst;
    @(posedge clk);
    model_edge(raw, rst);
    #1;
  endtask

  task automatic go_idle();
    tick(3'b000, 1'b1);
    tick(3'b000, 1'b1);
    repeat (3) tick(3'b000, 1'b0);
  endtask

  task automatic test_reset();
    for (int e = 0; e < 3; e++) begin
      tick(3'b111, 1'b1);
      tests_run++;
      if ({bus.pulse, bus.level, bus.busy} !== 7'b0) begin
        tests_failed++;
        $display("FAIL reset e=%0d: got p=%b l=%b b=%b want all 0", e, bus.pulse, bus.level, bus.busy);
      end
    end
  endtask

  task automatic test_clean_press();
    int npulse = 0;
    go_idle();
    for (int e = 0; e < 20; e++) begin
      tick(3'b001, 1'b0);
      tests_run++;
      if ({bus.pulse, bus.level, bus.busy} !== {m_pulse, m_level, |m_pend}) begin
        tests_failed++;
        $display("FAIL clean_model e=%0d: got p=%b l=%b b=%b want p=%b l=%b b=%b",
                 e, bus.pulse, bus.level, bus.busy, m_pulse, m_level, |m_pend);
      end
      if (bus.pulse != 3'b000) npulse++;
      if (e == 5 || e == 6 || e == 7) begin
        tests_run++;
        if (bus.level !== ((e >= 6) ? 3'b001 : 3'b000) || bus.pulse !== ((e == 7) ? 3'b001 : 3'b000)) begin
          tests_failed++;
          $display("FAIL clean_press e=%0d: got l=%b p=%b", e, bus.level, bus.pulse);
        end
      end
    end
    tests_run++;
    if (npulse !== 1) begin
      tests_failed++;
      $display("FAIL clean_pulse_count: got %0d want 1", npulse);
    end
    for (int e = 0; e < 10; e++) begin
      tick(3'b000, 1'b0);
      if (e == 5 || e == 6) begin
        tests_run++;
        if (bus.level !== ((e == 5) ? 3'b001 : 3'b000)) begin
          tests_failed++;
          $display("FAIL release e=%0d: got l=%b want %b", e, bus.level, (e == 5) ? 3'b001 : 3'b000);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int npulse = 0;
    logic [2:0] raw;
    go_idle();
    for (int e = 0; e < 24; e++) begin
      raw = (e >= 12 || (e % 4) < 2) ? 3'b010 : 3'b000;
      tick(raw, 1'b0);
      tests_run++;
      if ({bus.pulse, bus.level, bus.busy} !== {m_pulse, m_level, |m_pend}) begin
        tests_failed++;
        $display("FAIL bounce_model e=%0d: got p=%b l=%b b=%b want p=%b l=%b b=%b",
                 e, bus.pulse, bus.level, bus.busy, m_pulse, m_level, |m_pend);
      end
      if (bus.pulse != 3'b000) begin
        npulse++;
        tests_run++;
        if (e != 19 || bus.pulse !== 3'b010) begin
          tests_failed++;
          $display("FAIL bounce_pulse e=%0d: got %b want 010 only at e=19", e, bus.pulse);
        end
      end
    end
    tests_run++;
    if (npulse !== 1) begin
      tests_failed++;
      $display("FAIL bounce_pulse_count: got %0d want 1", npulse);
    end
  endtask

  task automatic test_glitch();
    go_idle();
    for (int e = 0; e < 13; e++) begin
      tick((e < 3) ? 3'b100 : 3'b000, 1'b0);
      tests_run++;
      if (bus.pulse !== 3'b000 || bus.level !== 3'b000) begin
        tests_failed++;
        $display("FAIL glitch e=%0d: got p=%b l=%b want 000 000", e, bus.pulse, bus.level);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_p;
    logic       exp_b;
    go_idle();
    for (int e = 0; e < 12; e++) begin
      tick(3'b111, 1'b0);
      exp_p = (e == 7) ? 3'b001 : (e == 8) ? 3'b010 : (e == 9) ? 3'b100 : 3'b000;
      exp_b = (e >= 6 && e <= 8);
      tests_run++;
      if (bus.pulse !== exp_p || bus.busy !== exp_b) begin
        tests_failed++;
        $display("FAIL simultaneous e=%0d: got p=%b b=%b want p=%b b=%b", e, bus.pulse, bus.busy, exp_p, exp_b);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic rst;
    go_idle();
    for (int e = 0; e < 20; e++) begin
      rst = (e == 4 || e == 5);
      tick(3'b001, rst);
      tests_run++;
      if (rst && {bus.pulse, bus.level, bus.busy} !== 7'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_zero e=%0d: got p=%b l=%b b=%b want all 0", e, bus.pulse, bus.level, bus.busy);
      end else if (bus.pulse !== ((e == 13) ? 3'b001 : 3'b000)) begin
        tests_failed++;
        $display("FAIL reset_mid_pulse e=%0d: got %b want %b", e, bus.pulse, (e == 13) ? 3'b001 : 3'b000);
      end
    end
  endtask

  task automatic test_autorepeat();
    int got[$];
    int want[$];
    want = AUTO ? '{7, 17, 27, 37} : '{7};
    go_idle();
    for (int e = 0; e < 40; e++) begin
      tick(3'b001, 1'b0);
      if (bus.pulse[0]) got.push_back(e);
      tests_run++;
      if ({bus.pulse, bus.level, bus.busy} !== {m_pulse, m_level, |m_pend}) begin
        tests_failed++;
        $display("FAIL repeat_model e=%0d: got p=%b l=%b b=%b want p=%b l=%b b=%b",
                 e, bus.pulse, bus.level, bus.busy, m_pulse, m_level, |m_pend);
      end
    end
    tests_run++;
    if (got.size() != want.size()) begin
      tests_failed++;
      $display("FAIL repeat_count: got %0d pulses want %0d", got.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        tests_run++;
        if (got[i] != want[i]) begin
          tests_failed++;
          $display("FAIL repeat_edge[%0d]: got %0d want %0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] raw = '0;
    int         hold[3] = '{0, 0, 0};
    logic       rst;
    go_idle();
    for (int e = 0; e < 1500; e++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          raw[c]  = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 14);
        end
        hold[c]--;
      end
      rst = ($urandom_range(0, 299) == 0);
      tick(raw, rst);
      tests_run++;
      if ({bus.pulse, bus.level, bus.busy} !== {m_pulse, m_level, |m_pend} || !$onehot0(bus.pulse)) begin
        tests_failed++;
        $display("FAIL random e=%0d raw=%b: got p=%b l=%b b=%b want p=%b l=%b b=%b",
                 e, raw, bus.pulse, bus.level, bus.busy, m_pulse, m_level, |m_pend);
      end
    end
  endtask

  initial begin
    bus.btn_raw = '0;
    for (int c = 0; c < 3; c++) begin m_run[c] = 0; m_rep[c] = 0; end
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_autorepeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/btn_cond.md
# btn_cond

Three-channel push-button conditioner for the vending-machine front end. It sits between the raw board buttons (coin C, coffee F, sprite P) and the vending FSM, on the 1 kHz divided clock. Per channel, it synchronises the input, debounces both edges, and turns each press into one single-cycle pulse. Presses that complete on the same cycle are serialised so that at most one pulse reaches the FSM per cycle.

## Interface
- DEBOUNCE_CYCLES, 20, consecutive stable cycles needed to accept a press or release edge (20 ms at 1 kHz); legal range ≥ 2
- REPEAT_CYCLES, 500, auto-repeat period in cycles; used only when auto-repeat is compiled in; legal range ≥ 2
- clk  input  1  1 kHz system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- btn_raw  input  3  asynchronous raw buttons; bit 0 = C (coin), bit 1 = F (coffee), bit 2 = P (sprite)
- pulse  output  3  one-hot or zero; single-cycle accepted-press strobe per channel
- level  output  3  debounced button level per channel
- busy  output  1  high while any pending press is not yet emitted

## Operation
- **Synchroniser.** Each channel has a 2-flop synchroniser; `sync` is the second flop.
- **Per-channel FSM.** States are IDLE, PRESS_WAIT, HELD and REL_WAIT. Each channel has one counter `cnt` with width `$clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES))`.
  - IDLE: sync=1 → PRESS_WAIT, cnt←0.
  - PRESS_WAIT: sync=0 → IDLE. Otherwise cnt++; when cnt==DEBOUNCE_CYCLES-1 → HELD, and set that channel's `pending` bit.
  - HELD: sync=0 → REL_WAIT, cnt←0.
  - REL_WAIT: sync=1 → HELD, with no new pending. Otherwise cnt++; when cnt==DEBOUNCE_CYCLES-1 → IDLE.
- **Level output.** `level[i]` = 1 while channel i is in HELD or REL_WAIT.
- **Arbiter.** Each cycle, the highest-priority set `pending` bit (C > F > P) drives `pulse` for one cycle and is cleared.
  - A pending bit being set on the same edge as another is emitted does not interfere.
  - A channel cannot re-arm before its bit drains: re-arming needs at least 2×DEBOUNCE_CYCLES cycles, and the worst-case drain is 3 cycles. No press is ever lost.
- **Busy output.** `busy` = OR of the pending bits.
- **Glitch rejection.** A glitch shorter than DEBOUNCE_CYCLES produces no pulse and no `level` change.

## Timing
- **Reset.** While reset is high:
  - all FSMs go to IDLE, `cnt`=0, pending=0, synchroniser flops=0;
  - `pulse`=0, `level`=0, `busy`=0.
- **Reset mid-operation.** Any in-progress debounce is abandoned. A button still held after reset deasserts is treated as a fresh press, and completes with full latency.
- **Latency.** Let edge k be the first clock edge that samples btn_raw[i]=1, with the input held stable afterwards.
  - sync=1 after edge k+1.
  - PRESS_WAIT after k+2.
  - `level[i]`=1 and pending set after edge k+2+DEBOUNCE_CYCLES.
  - `pulse[i]` high for the cycle after edge k+3+DEBOUNCE_CYCLES, when uncontended. Each higher-priority contender adds one cycle.
- **Release latency.** `level[i]` falls DEBOUNCE_CYCLES+2 edges after the first edge that samples 0.
- `pulse` is registered; it is never combinational from `btn_raw`.

## Configuration
- **Macro: BTN_COND_AUTOREPEAT_EN.**
- **Defined:**
  - While in HELD, `cnt` counts from 0, having been cleared on HELD entry.
  - When cnt==REPEAT_CYCLES-1, the channel re-sets its pending bit and clears cnt.
  - Repeat pulses therefore occur every REPEAT_CYCLES cycles after the first pulse.
  - REL_WAIT stops repeats.
- **Not defined:**
  - HELD never sets pending.
  - REPEAT_CYCLES is ignored, and the counter width uses DEBOUNCE_CYCLES only.

## Structure
- **Package `btn_cond_pkg`:**
  - channel index constants BTN_C=0, BTN_F=1, BTN_P=2;
  - the 2-bit FSM state enum (IDLE, PRESS_WAIT, HELD, REL_WAIT);
  - NUM_BTN=3.
- **Sub-module `btn_debounce_ch`:** one channel (synchroniser, FSM, counter, pending-set strobe). It is instantiated 3× in btn_cond.
- **Top level:** the pending register and the priority arbiter live in btn_cond.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=10, with reset released and btn_raw first sampled high at edge 0.
- **Clean press:** btn_raw=001 held for 20 cycles → `level[0]` rises after edge 6, `pulse`=001 for exactly one cycle after edge 7, and no other pulse. On release, `level[0]` falls 6 edges after the first 0 sample.
- **Bounce:** btn_raw[1] toggles every 2 cycles for 12 cycles, then stays high → no pulse during the bounce, then one `pulse`=010 at the 8th edge after the final rising sample.
- **Glitch:** btn_raw[2] high for 3 cycles → `pulse`=000 and `level`=000 throughout.
- **Simultaneous:** btn_raw 000→111 on one edge → `pulse`=001, 010, 100 on consecutive cycles after edges 7, 8 and 9. `busy` is high from after edge 6 until after edge 9.
- **Reset mid-press:** btn_raw=001 held, with reset high for edges 4–5 → all outputs are 0 during reset. The first post-reset edge sampling 1 counts as the new edge 0, and the pulse follows 8 edges later.
- **Auto-repeat:** btn_raw=001 held for 40 cycles.
  - With BTN_COND_AUTOREPEAT_EN: `pulse[0]` after edges 7, 17, 27 and 37.
  - Without it: only after edge 7.
